// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the
// instruction memory loader, plus the core hold and status flags.
//   byte_valid/byte_data/byte_ready : valid/ready byte stream into the loader
//   imem_we/imem_addr/imem_wdata    : single-cycle word write strobe, address, data
//   cpu_hold/done/error             : core hold and sticky load status
// Modports: master = stream source / memory+core side, slave = the loader.
interface imem_loader_if #(
   parameter int PC_WIDTH          = 8,
   parameter int INSTRUCTION_WIDTH = 32
);
   logic                         byte_valid;
   logic [7:0]                   byte_data;
   logic                         byte_ready;
   logic                         imem_we;
   logic [PC_WIDTH-1:0]          imem_addr;
   logic [INSTRUCTION_WIDTH-1:0] imem_wdata;
   logic                         cpu_hold;
   logic                         done;
   logic                         error;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a framed byte stream into little-endian instruction
// words and writes them sequentially into instruction memory, holding the core
// until a complete image with a matching XOR checksum has been received.
// Frame: START_BYTE, C, 4*(C+1) data bytes (LSB first), XOR checksum byte.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : imem_loader_if slave (byte stream in, imem write + status out)
// PC_WIDTH / INSTRUCTION_WIDTH must match the parameters of the bound interface.
module imem_loader #(
   parameter int         PC_WIDTH          = 8,
   parameter int         INSTRUCTION_WIDTH = 32,
   parameter logic [7:0] START_BYTE        = 8'hA5,
   parameter int         TIMEOUT_CYCLES    = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   imem_loader_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COUNT = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;

   localparam int             GAP_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES - 1);
   // 9 bits so that 2^8 is representable when PC_WIDTH == 8
   localparam logic [8:0]     MAX_WORDS = 9'(1 << PC_WIDTH);

   logic [2:0]                   state;
   logic [PC_WIDTH-1:0]          word_idx;
   logic [PC_WIDTH-1:0]          last_idx;   // N-1, i.e. the count byte C
   logic [1:0]                   byte_pos;
   logic [INSTRUCTION_WIDTH-9:0] word_buf;   // lower three bytes of the word in progress
   logic [7:0]                   csum;
   logic [GAP_W-1:0]             gap;
   logic [PC_WIDTH-1:0]          addr_q;
   logic [INSTRUCTION_WIDTH-1:0] wdata_q;
   logic                         hold_q, done_q, error_q;

   logic acc;
   logic in_frame;
   logic timeout;

   assign bus.byte_ready = !rst && (state != S_WRITE);
   assign bus.imem_we    = !rst && (state == S_WRITE);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_hold   = hold_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;

   assign acc      = bus.byte_valid && bus.byte_ready;
   assign in_frame = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
   assign timeout  = in_frame && !acc && (gap == GAP_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         word_idx <= '0;
         last_idx <= '0;
         byte_pos <= '0;
         word_buf <= '0;
         csum     <= '0;
         gap      <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         hold_q   <= 1'b1;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         // Every accepted byte and every state entry restarts the gap count;
         // entries from WRITE start at zero because WRITE holds it there.
         if (in_frame && !acc && !timeout) gap <= gap + GAP_W'(1);
         else                              gap <= '0;

         case (state)
            S_IDLE: begin
               if (acc && bus.byte_data == START_BYTE) begin
                  hold_q   <= 1'b1;
                  done_q   <= 1'b0;
                  error_q  <= 1'b0;
                  word_idx <= '0;
                  byte_pos <= '0;
                  csum     <= '0;
                  state    <= S_COUNT;
               end
            end
            S_COUNT: begin
               if (acc) begin
                  last_idx <= bus.byte_data[PC_WIDTH-1:0];
                  if ({1'b0, bus.byte_data} >= MAX_WORDS) begin
                     error_q <= 1'b1;
                     state   <= S_IDLE;
                  end else begin
                     state   <= S_DATA;
                  end
               end else if (timeout) begin
                  error_q <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            S_DATA: begin
               if (acc) begin
                  csum     <= csum ^ bus.byte_data;
                  byte_pos <= byte_pos + 2'd1;
                  if (byte_pos == 2'd3) begin
                     // Present the finished word on the bus during WRITE.
                     addr_q  <= word_idx;
                     wdata_q <= {bus.byte_data, word_buf};
                     state   <= S_WRITE;
                  end else begin
                     word_buf[{byte_pos, 3'b000} +: 8] <= bus.byte_data;
                  end
               end else if (timeout) begin
                  error_q <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            S_WRITE: begin
               word_idx <= word_idx + PC_WIDTH'(1);
               state    <= (word_idx == last_idx) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
               if (acc) begin
                  if (bus.byte_data == csum) begin
                     done_q <= 1'b1;
                     hold_q <= 1'b0;
                  end else begin
                     error_q <= 1'b1;
                  end
                  state <= S_IDLE;
               end else if (timeout) begin
                  error_q <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from word arrays, the
// expected write sequence and final status are derived from the frame rules.
module tb_imem_loader;
   localparam int PCW  = 4;
   localparam int TOC  = 16;
   localparam int MAXW = 1 << PCW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.PC_WIDTH(PCW)) bus ();

   imem_loader #(.PC_WIDTH(PCW), .TIMEOUT_CYCLES(TOC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] fw [MAXW];   // words of the frame under construction
   logic [7:0]  fq [$];      // its byte stream
   int          exp_addr [$];
   logic [31:0] exp_data [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Write-bus monitor against the expected write queue.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_rdy", bus.byte_ready, 1'b0);
         chk("rst_we", bus.imem_we, 1'b0);
      end else if (bus.imem_we) begin
         chk("wr_rdy", bus.byte_ready, 1'b0);
         if (exp_addr.size() == 0) chk("spurious_we", 1'b1, 1'b0);
         else begin
            chk("wr_addr", bus.imem_addr, exp_addr.pop_front());
            chk("wr_data", bus.imem_wdata, exp_data.pop_front());
         end
      end else begin
         chk("rdy", bus.byte_ready, 1'b1);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Starts and ends at posedge+1.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      @(negedge clk);
      while (!bus.byte_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("rdy_wait", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      for (int g = 0; g < n; g++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic build(input int c, input bit bad);
      logic [7:0] cs = 8'h00;
      fq.delete();
      fq.push_back(8'hA5);
      fq.push_back(8'(c));
      if (c < MAXW) begin
         for (int w = 0; w <= c; w++)
            for (int k = 0; k < 4; k++) begin
               fq.push_back(fw[w][8*k +: 8]);
               cs ^= fw[w][8*k +: 8];
            end
         fq.push_back(bad ? (cs ^ 8'h01) : cs);
      end
   endtask

   task automatic send_frame(input int c, input int stop, input int max_gap);
      for (int i = 0; i < fq.size() && i < stop; i++) begin
         if (i >= 2 && ((i - 2) % 4) == 3 && ((i - 2) / 4) <= c) begin
            exp_addr.push_back((i - 2) / 4);
            exp_data.push_back(fw[(i - 2) / 4]);
         end
         send_byte(fq[i]);
         if (i == 0) begin
            chk("start_done", bus.done, 1'b0);
            chk("start_err", bus.error, 1'b0);
            chk("start_hold", bus.cpu_hold, 1'b1);
         end
         idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic check_result(input bit ok);
      chk("done", bus.done, ok);
      chk("error", bus.error, !ok);
      chk("hold", bus.cpu_hold, !ok);
      chk("wr_left", exp_addr.size(), 0);
   endtask

   task automatic junk(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h00;
         send_byte(b);
      end
   endtask

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      idle(3);
      chk("rst_hold", bus.cpu_hold, 1'b1);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_error", bus.error, 1'b0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_wdata", bus.imem_wdata, 0);
      rst = 1'b0;
      idle(2);

      // Single word, with leading junk in IDLE.
      send_byte(8'h12);
      send_byte(8'h34);
      chk("junk_hold", bus.cpu_hold, 1'b1);
      fw[0] = 32'h00A00513;
      build(0, 1'b0);
      send_frame(0, 1000, 0);
      check_result(1'b1);

      // Two words, back to back.
      fw[0] = 32'h00000093;
      fw[1] = 32'h7FF00113;
      build(1, 1'b0);
      send_frame(1, 1000, 0);
      check_result(1'b1);

      // Bad checksum: the write still happens.
      fw[0] = 32'h00A00513;
      build(0, 1'b1);
      send_frame(0, 1000, 1);
      check_result(1'b0);

      // Timeout after one data byte.
      build(0, 1'b0);
      send_frame(0, 3, 0);
      idle(TOC - 1);
      chk("to_early", bus.error, 1'b0);
      idle(1);
      chk("to_err", bus.error, 1'b1);
      chk("to_done", bus.done, 1'b0);
      chk("to_hold", bus.cpu_hold, 1'b1);
      build(0, 1'b0);
      send_frame(0, 1000, 2);
      check_result(1'b1);

      // Reset after the second data byte.
      fw[0] = 32'hDEADBEEF;
      fw[1] = 32'h00A5A5A5;
      build(1, 1'b0);
      send_frame(1, 4, 0);
      rst = 1'b1;
      idle(1);
      chk("mr_hold", bus.cpu_hold, 1'b1);
      chk("mr_done", bus.done, 1'b0);
      chk("mr_err", bus.error, 1'b0);
      chk("mr_addr", bus.imem_addr, 0);
      chk("mr_wdata", bus.imem_wdata, 0);
      rst = 1'b0;
      idle(1);
      build(1, 1'b0);
      send_frame(1, 1000, 1);
      check_result(1'b1);

      // Oversize count, then the largest legal image.
      build(MAXW, 1'b0);
      send_frame(MAXW, 1000, 0);
      chk("big_err", bus.error, 1'b1);
      chk("big_done", bus.done, 1'b0);
      chk("big_hold", bus.cpu_hold, 1'b1);
      chk("big_wr", exp_addr.size(), 0);
      for (int w = 0; w < MAXW; w++) fw[w] = $urandom;
      build(MAXW - 1, 1'b0);
      send_frame(MAXW - 1, 1000, 1);
      check_result(1'b1);

      // Random frames.
      for (int f = 0; f < 12; f++) begin
         int c;
         bit bad;
         c   = $urandom_range(0, MAXW - 1);
         bad = ($urandom_range(0, 3) == 0);
         for (int w = 0; w < MAXW; w++) fw[w] = $urandom;
         junk($urandom_range(0, 2));
         build(c, bad);
         send_frame(c, 1000, 3);
         check_result(!bad);
      end

      idle(3);
      chk("end_wr_left", exp_addr.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
